// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-stage LSU: FSM states, funct3 size codes,
// error codes and the byte-lane mask helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_D    = 3'b011;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;
    localparam logic [2:0] F3_WU   = 3'b110;
    localparam logic [2:0] F3_RSVD = 3'b111;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    // Contiguous 1/2/4/8-byte mask placed at the byte offset; callers keep the low DATA_W/8 bits.
    function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Ready-based memory bus between the LSU (master) and the data memory (slave).
interface mem_stage_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W/8-1:0]   mem_be_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W-1:0]     mem_rdata_i;
    logic                  mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_rdata_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_rdata_i, mem_ready_i
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load lane select with sign/zero extension.
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                    i_size,
    input  logic [$clog2(DATA_W/8)-1:0]   i_off,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic [DATA_W-1:0]             i_rdata,
    output logic [DATA_W/8-1:0]           o_be,
    output logic [DATA_W-1:0]             o_wdata,
    output logic [DATA_W-1:0]             o_rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] w_ones;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_keep;
    logic [DATA_W-1:0] w_top;
    logic [6:0]        w_nbits;
    logic              w_neg;

    assign o_be = NB'(byte_mask(i_size, 3'(i_off)));

    always_comb begin
        o_wdata = i_wdata;
        case (i_size[1:0])
            2'b00:   o_wdata = {NB{i_wdata[7:0]}};
            2'b01:   o_wdata = {(NB/2){i_wdata[15:0]}};
            2'b10:   o_wdata = {(NB/4){i_wdata[31:0]}};
            default: o_wdata = i_wdata;
        endcase
    end

    // w_top isolates the sign bit of the selected field; a shift past DATA_W keeps every bit.
    assign w_ones  = '1;
    assign w_shift = i_rdata >> {i_off, 3'b000};
    assign w_nbits = 7'd8 << i_size[1:0];
    assign w_keep  = ~(w_ones << w_nbits);
    assign w_top   = w_keep & ~(w_keep >> 1);
    assign w_neg   = ~i_size[2] & (|(w_shift & w_top));
    assign o_rdata = (w_shift & w_keep) | (w_neg ? ~w_keep : '0);

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit driving a variable-latency ready-based memory bus.
// Optional MEM_STAGE_MISALIGN_TRAP_EN: misaligned accesses complete with an error instead of being aligned down.
//   state | meaning
//   IDLE  | waiting for a load/store in M; accepts and stalls in the same cycle
//   BUSY  | request on the bus, waiting for mem_ready_i or the watchdog
//   DONE  | one-cycle completion, result and error presented, stall released
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                MemValidM_i,
    input  logic                MemReadM_i,
    input  logic                MemWriteM_i,
    input  logic [2:0]          MemCtrlM_i,
    input  logic [ADDR_W-1:0]   ALUResultM_i,
    input  logic [DATA_W-1:0]   WriteDataM_i,
    output logic [DATA_W-1:0]   ReadDataM_o,
    output logic                DoneM_o,
    output logic                StallM_o,
    output logic [1:0]          ErrM_o,
    mem_stage_lsu_if.master     mem
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

    state_t              r_state;
    logic                r_req;
    logic                r_we;
    logic                r_done;
    logic [1:0]          r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_addr;
    logic [NB-1:0]       r_be;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_size;
    logic [OFF_W-1:0]    r_off;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_start;
    logic                w_illegal;
    logic [OFF_W-1:0]    w_off;
    logic [OFF_W-1:0]    w_lowmask;
    logic [OFF_W-1:0]    w_off_eff;
    logic [OFF_W-1:0]    w_al_off;
    logic [2:0]          w_al_size;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_wrep;
    logic [DATA_W-1:0]   w_rext;
    logic [CNT_W-1:0]    w_cnt_inc;

    assign w_start   = MemValidM_i & (MemReadM_i | MemWriteM_i);
    assign w_illegal = (MemCtrlM_i == F3_RSVD) ||
                       ((DATA_W == 32) && ((MemCtrlM_i == F3_D) || (MemCtrlM_i == F3_WU)));
    assign w_off     = ALUResultM_i[OFF_W-1:0];
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_lowmask = '1;
        case (MemCtrlM_i[1:0])
            2'b00:   w_lowmask = '0;
            2'b01:   w_lowmask = OFF_W'(1);
            2'b10:   w_lowmask = OFF_W'(3);
            default: w_lowmask = '1;
        endcase
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic w_misal;
    assign w_misal   = |(w_off & w_lowmask);
    assign w_off_eff = w_off;
`else
    assign w_off_eff = w_off & ~w_lowmask;
`endif

    // One lane unit serves both paths: incoming request fields in IDLE, the held load in BUSY.
    assign w_al_size = (r_state == IDLE) ? MemCtrlM_i : r_size;
    assign w_al_off  = (r_state == IDLE) ? w_off_eff  : r_off;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .i_size  (w_al_size),
        .i_off   (w_al_off),
        .i_wdata (WriteDataM_i),
        .i_rdata (mem.mem_rdata_i),
        .o_be    (w_be),
        .o_wdata (w_wrep),
        .o_rdata (w_rext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= ERR_NONE;
            r_rdata <= '0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_size  <= F3_B;
            r_off   <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (w_illegal) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= ERR_SIZE;
                            r_rdata <= '0;
                        end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                        else if (w_misal) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= ERR_MISALIGN;
                            r_rdata <= '0;
                        end
`endif
                        else begin
                            r_state <= BUSY;
                            r_req   <= 1'b1;
                            r_we    <= MemWriteM_i;
                            r_addr  <= {ALUResultM_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            r_be    <= w_be;
                            r_wdata <= w_wrep;
                            r_size  <= MemCtrlM_i;
                            r_off   <= w_off_eff;
                            r_cnt   <= '0;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= w_cnt_inc;
                    if (mem.mem_ready_i) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= ERR_NONE;
                        r_rdata <= r_we ? '0 : w_rext;
                    end else if ((TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
                        r_state <= DONE;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= ERR_TIMEOUT;
                        r_rdata <= '0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_err   <= ERR_NONE;
                    r_rdata <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign StallM_o        = rst_n & (((r_state == IDLE) & w_start) | (r_state == BUSY));
    assign DoneM_o         = r_done;
    assign ErrM_o          = r_err;
    assign ReadDataM_o     = r_rdata;
    assign mem.mem_req_o   = r_req;
    assign mem.mem_we_o    = r_we;
    assign mem.mem_addr_o  = r_addr;
    assign mem.mem_be_o    = r_be;
    assign mem.mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu (DATA_W=32, TIMEOUT_CYCLES=4): directed table, random accesses
// against a byte-level reference model, and reset/idle corner sequences.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemValidM_i, MemReadM_i, MemWriteM_i;
    logic [2:0]  MemCtrlM_i;
    logic [31:0] ALUResultM_i, WriteDataM_i, ReadDataM_o;
    logic        DoneM_o, StallM_o;
    logic [1:0]  ErrM_o;

    int total = 0;
    int bad   = 0;

    mem_stage_lsu_if #(.DATA_W(32), .ADDR_W(32)) mif ();

    mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemValidM_i  (MemValidM_i),
        .MemReadM_i   (MemReadM_i),
        .MemWriteM_i  (MemWriteM_i),
        .MemCtrlM_i   (MemCtrlM_i),
        .ALUResultM_i (ALUResultM_i),
        .WriteDataM_i (WriteDataM_i),
        .ReadDataM_o  (ReadDataM_o),
        .DoneM_o      (DoneM_o),
        .StallM_o     (StallM_o),
        .ErrM_o       (ErrM_o),
        .mem          (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ra;       // BUSY cycle (1-based) on which ready is given; 0 = never
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
        int          e_busy;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] ctrl,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ra,
                                input logic [1:0] e_err, input logic [31:0] e_rdata,
                                input int e_busy, input logic [31:0] e_addr,
                                input logic [3:0] e_be, input logic [31:0] e_wdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.ra = ra; v.e_err = e_err; v.e_rdata = e_rdata;
        v.e_busy = e_busy; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Reference model: sizes in bytes, lane arithmetic on integers.
    function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] ctrl,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata, input int ra);
        vec_t   v;
        int     nb, off, offe;
        longint val, span;
        v  = mk(rd, wr, ctrl, addr, wdata, rdata, ra, 2'b00, 32'h0, 0, 32'h0, 4'h0, 32'h0);
        nb = 1 << ctrl[1:0];
        off = int'(addr % 4);
        if (ctrl == 3'b011 || ctrl == 3'b110 || ctrl == 3'b111) begin
            v.e_err = 2'b11;
            return v;
        end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        if (off % nb != 0) begin
            v.e_err = 2'b01;
            return v;
        end
`endif
        offe      = off - (off % nb);
        v.e_addr  = addr - 32'(off);
        v.e_be    = 4'(((1 << nb) - 1) << offe);
        for (int i = 0; i < 4; i++) v.e_wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
        if (ra == 0) begin
            v.e_busy  = 4;
            v.e_err   = 2'b10;
            v.e_rdata = 32'h0;
        end else begin
            v.e_busy = ra;
            v.e_err  = 2'b00;
            if (wr) begin
                v.e_rdata = 32'h0;
            end else begin
                span = longint'(1) << (8 * nb);
                val  = (longint'(rdata) >> (8 * offe)) % span;
                if (!ctrl[2] && val >= span / 2) val = val - span;
                v.e_rdata = 32'(val);
            end
        end
        return v;
    endfunction

    // Starts at posedge+1 in IDLE; returns at posedge+1 with the DUT idle again.
    task automatic apply_vec(input string tag, input vec_t v);
        int          busy, stalls, dones;
        logic [1:0]  err;
        logic [31:0] rdo, a_c, wd_c;
        logic [3:0]  be_c;
        logic        we_c;
        bit          stable;
        busy = 0; stalls = 0; dones = 0; stable = 1'b1;
        err = 2'b00; rdo = 32'h0; a_c = 32'h0; wd_c = 32'h0; be_c = 4'h0; we_c = 1'b0;
        MemValidM_i  = 1'b1;
        MemReadM_i   = v.rd;
        MemWriteM_i  = v.wr;
        MemCtrlM_i   = v.ctrl;
        ALUResultM_i = v.addr;
        WriteDataM_i = v.wdata;
        for (int cyc = 0; cyc < 20 && dones == 0; cyc++) begin
            @(negedge clk);
            if (StallM_o) stalls++;
            if (mif.mem_req_o) begin
                busy++;
                if (busy == 1) begin
                    a_c = mif.mem_addr_o; be_c = mif.mem_be_o;
                    wd_c = mif.mem_wdata_o; we_c = mif.mem_we_o;
                end else if (mif.mem_addr_o !== a_c || mif.mem_be_o !== be_c ||
                             mif.mem_wdata_o !== wd_c || mif.mem_we_o !== we_c) begin
                    stable = 1'b0;
                end
                mif.mem_ready_i = (busy == v.ra);
                mif.mem_rdata_i = (busy == v.ra) ? v.rdata : $urandom;
            end else begin
                mif.mem_ready_i = 1'($urandom_range(0, 1));
                mif.mem_rdata_i = $urandom;
            end
            if (DoneM_o) begin
                dones++;
                err = ErrM_o;
                rdo = ReadDataM_o;
                MemValidM_i = 1'b0;
                MemReadM_i  = 1'b0;
                MemWriteM_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk({tag, ".done"}, 64'(dones), 64'd1);
        chk({tag, ".err"}, 64'(err), 64'(v.e_err));
        chk({tag, ".rdata"}, 64'(rdo), 64'(v.e_rdata));
        chk({tag, ".busy_cycles"}, 64'(busy), 64'(v.e_busy));
        chk({tag, ".stall_cycles"}, 64'(stalls), 64'(v.e_busy + 1));
        if (v.e_busy > 0) begin
            chk({tag, ".addr"}, 64'(a_c), 64'(v.e_addr));
            chk({tag, ".be"}, 64'(be_c), 64'(v.e_be));
            chk({tag, ".wdata"}, 64'(wd_c), 64'(v.e_wdata));
            chk({tag, ".we"}, 64'(we_c), 64'(v.wr));
            chk({tag, ".stable"}, 64'(stable), 64'd1);
        end
        @(negedge clk);
        chk({tag, ".idle_after"}, 64'({mif.mem_req_o, DoneM_o, StallM_o}), 64'd0);
        mif.mem_ready_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  nreq;
        bit  hit;
        rst_n = 1'b0;
        MemValidM_i = 1'b0; MemReadM_i = 1'b0; MemWriteM_i = 1'b0;
        MemCtrlM_i = 3'b000; ALUResultM_i = 32'h0; WriteDataM_i = 32'h0;
        mif.mem_ready_i = 1'b0;
        mif.mem_rdata_i = 32'h0;

        //           rd wr ctrl     addr      wdata         rdata         ra err    e_rdata       busy e_addr    be     e_wdata
        tbl.push_back(mk(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1, 2'b00, 32'h0,        1, 32'h100, 4'hF, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1, 2'b00, 32'h0,        1, 32'h100, 4'h8, 32'hA5A5A5A5));
        tbl.push_back(mk(1, 0, 3'b000, 32'h102, 32'h0,        32'h12F03456, 1, 2'b00, 32'hFFFFFFF0, 1, 32'h100, 4'h4, 32'h0));
        tbl.push_back(mk(1, 0, 3'b100, 32'h102, 32'h0,        32'h12F03456, 1, 2'b00, 32'h000000F0, 1, 32'h100, 4'h4, 32'h0));
        tbl.push_back(mk(1, 0, 3'b001, 32'h102, 32'h0,        32'h12F03456, 1, 2'b00, 32'h000012F0, 1, 32'h100, 4'hC, 32'h0));
        tbl.push_back(mk(1, 0, 3'b010, 32'h104, 32'h0,        32'h0,        0, 2'b10, 32'h0,        4, 32'h104, 4'hF, 32'h0));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        tbl.push_back(mk(1, 0, 3'b001, 32'h101, 32'h0,        32'h12F03456, 1, 2'b01, 32'h0,        0, 32'h0,   4'h0, 32'h0));
`else
        tbl.push_back(mk(1, 0, 3'b001, 32'h101, 32'h0,        32'h12F03456, 1, 2'b00, 32'h00003456, 1, 32'h100, 4'h3, 32'h0));
`endif
        tbl.push_back(mk(1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 2'b11, 32'h0,        0, 32'h0,   4'h0, 32'h0));
        tbl.push_back(mk(1, 0, 3'b110, 32'h100, 32'h0,        32'h0,        1, 2'b11, 32'h0,        0, 32'h0,   4'h0, 32'h0));
        tbl.push_back(mk(0, 1, 3'b111, 32'h100, 32'h0,        32'h0,        1, 2'b11, 32'h0,        0, 32'h0,   4'h0, 32'h0));
        tbl.push_back(mk(1, 0, 3'b001, 32'h100, 32'h0,        32'h00008001, 3, 2'b00, 32'hFFFF8001, 3, 32'h100, 4'h3, 32'h0));
        tbl.push_back(mk(0, 1, 3'b001, 32'h106, 32'h1234ABCD, 32'h0,        2, 2'b00, 32'h0,        2, 32'h104, 4'hC, 32'hABCDABCD));
        tbl.push_back(mk(1, 0, 3'b010, 32'h108, 32'h0,        32'h87654321, 2, 2'b00, 32'h87654321, 2, 32'h108, 4'hF, 32'h0));
        tbl.push_back(mk(1, 0, 3'b101, 32'h10A, 32'h0,        32'h87654321, 1, 2'b00, 32'h00008765, 1, 32'h108, 4'hC, 32'h0));
        tbl.push_back(mk(1, 1, 3'b010, 32'h10C, 32'h11223344, 32'h55667788, 1, 2'b00, 32'h0,        1, 32'h10C, 4'hF, 32'h11223344));
        tbl.push_back(mk(1, 0, 3'b000, 32'h203, 32'h0,        32'h80123456, 2, 2'b00, 32'hFFFFFF80, 2, 32'h200, 4'h8, 32'h0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.outputs", 64'({mif.mem_req_o, DoneM_o, StallM_o, ErrM_o}), 64'd0);
        chk("reset.rdata", 64'(ReadDataM_o), 64'd0);
        chk("reset.bus", 64'({mif.mem_we_o, mif.mem_be_o, mif.mem_addr_o, mif.mem_wdata_o}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ready with nothing in flight must not complete anything.
        mif.mem_ready_i = 1'b1;
        hit = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (DoneM_o || mif.mem_req_o) hit = 1'b1;
        end
        chk("idle_ready.no_done", 64'(hit), 64'd0);
        @(posedge clk); #1;
        mif.mem_ready_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 150; i++) begin
            int   rw;
            vec_t v;
            rw = int'($urandom_range(1, 3));
            v = model(1'(rw & 1), 1'((rw >> 1) & 1), 3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom, int'($urandom_range(0, 3)));
            apply_vec($sformatf("rnd%0d", i), v);
        end

        // Reset during the third BUSY cycle of a hanging load.
        MemValidM_i = 1'b1; MemReadM_i = 1'b1; MemWriteM_i = 1'b0;
        MemCtrlM_i = 3'b010; ALUResultM_i = 32'h200;
        mif.mem_ready_i = 1'b0;
        nreq = 0;
        for (int cyc = 0; cyc < 10 && nreq < 3; cyc++) begin
            @(negedge clk);
            if (mif.mem_req_o) nreq++;
            if (nreq == 3) begin
                rst_n = 1'b0;
                MemValidM_i = 1'b0;
                MemReadM_i  = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("rst_busy.reached_third", 64'(nreq), 64'd3);
        @(negedge clk);
        chk("rst_busy.idle", 64'({mif.mem_req_o, StallM_o, DoneM_o}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mif.mem_ready_i = 1'b1;
        mif.mem_rdata_i = 32'hFFFFFFFF;
        hit = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (DoneM_o || mif.mem_req_o || StallM_o) hit = 1'b1;
        end
        chk("rst_busy.late_ready_ignored", 64'(hit), 64'd0);
        @(posedge clk); #1;
        mif.mem_ready_i = 1'b0;

        apply_vec("after_rst", tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the single-cycle memory-stage wrapper in the RV32I pipeline.
- Turns M-stage load/store requests into a variable-latency ready-based memory transaction.
- Generates byte enables and store-lane replication, and extracts load data with sign or zero extension.
- Stalls the pipeline while an access is outstanding; a watchdog aborts hung accesses.

Parameters:
- DATA_W, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 64, BUSY cycles allowed without mem_ready_i before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- MemValidM_i  in  1  M-stage holds a valid instruction.
- MemReadM_i  in  1  load.
- MemWriteM_i  in  1  store.
- MemCtrlM_i  in  3  funct3 size code: 000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (64 only).
- ALUResultM_i  in  ADDR_W  byte address.
- WriteDataM_i  in  DATA_W  store data, right-aligned.
- ReadDataM_o  out  DATA_W  extended load data; valid while DoneM_o=1.
- DoneM_o  out  1  access complete this cycle.
- StallM_o  out  1  hold IF..M stages.
- ErrM_o  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal size; valid while DoneM_o=1.
- mem_req_o  out  1  request to memory.
- mem_we_o  out  1  write request.
- mem_addr_o  out  ADDR_W  address aligned to DATA_W/8.
- mem_be_o  out  DATA_W/8  byte enables.
- mem_wdata_o  out  DATA_W  lane-replicated store data.
- mem_rdata_i  in  DATA_W  read data, valid with mem_ready_i.
- mem_ready_i  in  1  memory completes the request this cycle.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (rst_n=0 at a rising edge): state IDLE, all outputs 0, watchdog counter 0.
- start = MemValidM_i & (MemReadM_i | MemWriteM_i).
- If MemReadM_i and MemWriteM_i are both 1, treat the access as a store.
- IDLE, start, legal and aligned:
  - Register address, size, data and we.
  - Next state BUSY.
  - StallM_o=1 combinationally in that same cycle.
- IDLE, start, illegal size (011/110 with DATA_W=32, or 111): next state DONE with ErrM_o=11; no memory request.
- BUSY:
  - mem_req_o=1; request fields held stable.
  - StallM_o=1; watchdog counter increments.
  - On mem_ready_i=1: capture mem_rdata_i, next state DONE.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES first: next state DONE, ErrM_o=10, ReadDataM_o=0, mem_req_o dropped.
- DONE:
  - One cycle: DoneM_o=1, StallM_o=0, ReadDataM_o and ErrM_o valid.
  - Inputs ignored, because they still show the same instruction.
  - Next state IDLE.
- Minimum latency: accept cycle, then one BUSY cycle with ready, then DONE. That is 3 cycles per access; StallM_o is high for 2 of them.
- Byte offset = ALUResultM_i[log2(DATA_W/8)-1:0].
- mem_be_o: a contiguous 1/2/4/8-byte mask shifted by the offset.
- mem_wdata_o: WriteDataM_i low bytes replicated across all lanes.
- Loads: select lanes by offset, then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to DATA_W. For a store, ReadDataM_o=0 in DONE.
- Reset mid-BUSY: return to IDLE on that edge, mem_req_o deasserted, late mem_ready_i ignored.
- mem_ready_i outside BUSY is ignored.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined: an access whose offset is not a multiple of its size goes IDLE->DONE with ErrM_o=01; no mem_req_o, no write.
- Undefined: offset low bits are forced to the natural alignment of the size (H clears bit0, W clears bits[1:0]) and the access proceeds; ErrM_o never reports 01.

Decomposition:
- Package mem_stage_pkg holds:
  - State enum: IDLE, BUSY, DONE.
  - funct3 size constants.
  - ErrM_o codes.
  - Function computing the byte mask from size and offset.
- Sub-module lsu_align (combinational): byte-enable generation, store replication, load lane select and extension. Shared by the store and load paths.

Test Plan:
- SW 0xDEADBEEF to 0x100, ready on the 1st BUSY cycle -> mem_be_o=1111, mem_wdata_o=0xDEADBEEF, StallM_o high 2 cycles, DoneM_o 1 cycle, ErrM_o=00.
- SB 0x000000A5 to 0x103 -> mem_addr_o=0x100, mem_be_o=1000, mem_wdata_o=0xA5A5A5A5.
- LB from 0x102 with mem_rdata_i=0x12F0_3456 -> ReadDataM_o=0xFFFFFFF0; LBU -> 0x000000F0; LH from 0x102 -> 0x000012F0.
- LW with ready withheld and TIMEOUT_CYCLES=4 -> 4 BUSY cycles, then DONE with ErrM_o=10, ReadDataM_o=0, mem_req_o low afterwards.
- LH from 0x101 -> with macro: ErrM_o=01, no mem_req_o; without macro: mem_addr_o=0x100, mem_be_o=0011.
- rst_n=0 during the 3rd BUSY cycle -> next cycle IDLE, mem_req_o=0, StallM_o=0; a following mem_ready_i produces no DoneM_o.
